calc_cmd_initiator: RTL and testbench

- Initiator side of the 4-bit calculator operand interface.
- Accepts tagged operation commands over a valid/ready handshake and drives the calculator's A/B/Op inputs.
- Waits a fixed settle time, then captures the 5-bit Result and returns it over a valid/ready response channel with decoded flags.
- Keeps a 4-bit accumulator so commands can chain on the previous result.

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_cmd_initiator.sv | 136 +++++++++++++
 tb/tb_calc_cmd_initiator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand interface: widths, op codes
// and the initiator state encoding.
package calc_pkg;

  localparam int DATA_W = 4;
  localparam int RES_W  = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/calc_cmd_initiator.sv
// Initiator for the 4-bit calculator: takes tagged commands, drives the
// calculator operands, waits for the result to settle and returns it with flags.
module calc_cmd_initiator
  import calc_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_use_acc,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  output logic [1:0]        calc_op,
  input  logic [RES_W-1:0]  calc_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_zero,
  output logic              rsp_cb,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  if ((SETTLE < 1) || (SETTLE > 15)) begin : g_bad_settle
    $error("calc_cmd_initiator: SETTLE must be within 1..15");
  end

  // Loading SETTLE (not SETTLE-1) puts the capture edge SETTLE+1 edges after accept.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_calc_a;
  logic [DATA_W-1:0]   r_calc_b;
  logic [1:0]          r_calc_op;
  logic [TAG_W-1:0]    r_tag;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [RES_W-1:0]    r_rsp_result;
  logic [TAG_W-1:0]    r_rsp_tag;
  logic                r_rsp_zero;
  logic                r_rsp_cb;
  logic [CNT_W-1:0]    r_op_count;
  logic                w_is_arith;

  assign w_is_arith = (r_calc_op == OP_ADD) || (r_calc_op == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_calc_a     <= '0;
      r_calc_b     <= '0;
      r_calc_op    <= '0;
      r_tag        <= '0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_cb     <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_calc_a    <= cmd_use_acc ? r_acc : cmd_a;
            r_calc_b    <= cmd_b;
            r_calc_op   <= cmd_op;
            r_tag       <= cmd_tag;
            r_cnt       <= SETTLE_LD;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_cnt == 4'd0) begin
            r_rsp_result <= calc_result;
            r_rsp_zero   <= (calc_result == '0);
            r_rsp_cb     <= w_is_arith & calc_result[RES_W-1];
            r_rsp_tag    <= r_tag;
            r_acc        <= calc_result[DATA_W-1:0];
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_op_count != {CNT_W{1'b1}}) begin
              r_op_count <= r_op_count + 1'b1;
            end
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign calc_a     = r_calc_a;
  assign calc_b     = r_calc_b;
  assign calc_op    = r_calc_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_cb     = r_rsp_cb;
  assign busy       = r_busy;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_calc_cmd_initiator.sv
// Directed bench for calc_cmd_initiator: a SETTLE=1 instance plus a SETTLE=4,
// CNT_W=2 instance, each beside a behavioural 4-bit calculator.
module tb_calc_cmd_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Main instance, SETTLE=1
  logic       cmd_valid = 1'b0, cmd_use_acc = 1'b0, rsp_ready = 1'b1;
  logic [3:0] cmd_a = '0, cmd_b = '0, cmd_tag = '0;
  logic [1:0] cmd_op = '0;
  logic       cmd_ready, rsp_valid, rsp_zero, rsp_cb, busy;
  logic [3:0] calc_a, calc_b, rsp_tag;
  logic [1:0] calc_op;
  logic [4:0] calc_result, rsp_result;
  logic [7:0] op_count;
  logic       calc_junk = 1'b0;

  // Second instance, SETTLE=4, CNT_W=2
  logic       cmd_valid2 = 1'b0, rsp_ready2 = 1'b1;
  logic [3:0] cmd_a2 = '0, cmd_b2 = '0;
  logic [1:0] cmd_op2 = '0;
  logic       cmd_ready2, rsp_valid2, rsp_zero2, rsp_cb2, busy2;
  logic [3:0] calc_a2, calc_b2, rsp_tag2;
  logic [1:0] calc_op2;
  logic [4:0] calc_result2, rsp_result2;
  logic [1:0] op_count2;

  // Behavioural calculator; calc_junk drives bit 4 high on AND/OR results.
  always_comb begin
    case (calc_op)
      2'b00:   calc_result = {1'b0, calc_a} + {1'b0, calc_b};
      2'b01:   calc_result = {1'b0, calc_a} - {1'b0, calc_b};
      2'b10:   calc_result = {calc_junk, calc_a & calc_b};
      default: calc_result = {calc_junk, calc_a | calc_b};
    endcase
  end

  always_comb begin
    case (calc_op2)
      2'b00:   calc_result2 = {1'b0, calc_a2} + {1'b0, calc_b2};
      2'b01:   calc_result2 = {1'b0, calc_a2} - {1'b0, calc_b2};
      2'b10:   calc_result2 = {1'b0, calc_a2 & calc_b2};
      default: calc_result2 = {1'b0, calc_a2 | calc_b2};
    endcase
  end

  calc_cmd_initiator #(.TAG_W(4), .SETTLE(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc), .cmd_tag(cmd_tag),
    .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_result(calc_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .rsp_cb(rsp_cb),
    .busy(busy), .op_count(op_count)
  );

  calc_cmd_initiator #(.TAG_W(4), .SETTLE(4), .CNT_W(2)) u_dut_s4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_a(cmd_a2), .cmd_b(cmd_b2),
    .cmd_op(cmd_op2), .cmd_use_acc(1'b0), .cmd_tag(4'd0),
    .calc_a(calc_a2), .calc_b(calc_b2), .calc_op(calc_op2), .calc_result(calc_result2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_result(rsp_result2),
    .rsp_tag(rsp_tag2), .rsp_zero(rsp_zero2), .rsp_cb(rsp_cb2),
    .busy(busy2), .op_count(op_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command to the main instance and wait (bounded) for rsp_valid.
  // lat counts edges from the acceptance edge to the first edge showing rsp_valid.
  task automatic run_main(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic ua, input logic [3:0] tag, output int lat);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua; cmd_tag = tag;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    $display("txn main a=%0d b=%0d op=%0d acc=%0d tag=%0d -> result=%0d cb=%0b zero=%0b lat=%0d",
             a, b, op, ua, tag, rsp_result, rsp_cb, rsp_zero, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_total++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100)
      $display("FAIL reset_ctrl got ready/valid/busy=%b want 100", {cmd_ready, rsp_valid, busy});
    else n_pass++;
    n_total++;
    if ({calc_a, calc_b, calc_op} !== 10'd0)
      $display("FAIL reset_calc got %h want 0", {calc_a, calc_b, calc_op});
    else n_pass++;
    n_total++;
    if ({rsp_result, rsp_tag, rsp_zero, rsp_cb, op_count} !== 19'd0)
      $display("FAIL reset_rsp got %h want 0", {rsp_result, rsp_tag, rsp_zero, rsp_cb, op_count});
    else n_pass++;
    $display("txn reset done");
  endtask

  task automatic test_add();
    int lat;
    run_main(4'd9, 4'd8, 2'b00, 1'b0, 4'd3, lat);
    n_total++;
    if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else n_pass++;
    n_total++;
    if (rsp_result !== 5'd17) $display("FAIL add_result got %0d want 17", rsp_result); else n_pass++;
    n_total++;
    if ({rsp_cb, rsp_zero, rsp_tag} !== {1'b1, 1'b0, 4'd3})
      $display("FAIL add_flags got cb=%b zero=%b tag=%0d want 1 0 3", rsp_cb, rsp_zero, rsp_tag);
    else n_pass++;
    tick();
    n_total++;
    if ({op_count, rsp_valid, cmd_ready} !== {8'd1, 1'b0, 1'b1})
      $display("FAIL add_done got count=%0d valid=%b ready=%b want 1 0 1", op_count, rsp_valid, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_chain();
    int lat;
    run_main(4'd3, 4'd5, 2'b01, 1'b0, 4'd1, lat);
    n_total++;
    if ({rsp_result, rsp_cb, rsp_zero} !== {5'd30, 1'b1, 1'b0})
      $display("FAIL sub_borrow got result=%0d cb=%b zero=%b want 30 1 0", rsp_result, rsp_cb, rsp_zero);
    else n_pass++;
    tick();
    run_main(4'd7, 4'd2, 2'b00, 1'b1, 4'd2, lat);
    n_total++;
    if (calc_a !== 4'd14) $display("FAIL chain_calc_a got %0d want 14", calc_a); else n_pass++;
    n_total++;
    if ({rsp_result, rsp_cb, rsp_tag} !== {5'd16, 1'b1, 4'd2})
      $display("FAIL chain_result got result=%0d cb=%b tag=%0d want 16 1 2", rsp_result, rsp_cb, rsp_tag);
    else n_pass++;
    tick();
    n_total++;
    if (op_count !== 8'd3) $display("FAIL chain_count got %0d want 3", op_count); else n_pass++;
  endtask

  task automatic test_logic();
    int lat;
    run_main(4'd12, 4'd10, 2'b10, 1'b0, 4'd4, lat);
    n_total++;
    if ({rsp_result, rsp_cb, rsp_zero} !== {5'd8, 1'b0, 1'b0})
      $display("FAIL and_result got result=%0d cb=%b zero=%b want 8 0 0", rsp_result, rsp_cb, rsp_zero);
    else n_pass++;
    tick();
    run_main(4'd0, 4'd0, 2'b11, 1'b0, 4'd5, lat);
    n_total++;
    if ({rsp_result, rsp_cb, rsp_zero} !== {5'd0, 1'b0, 1'b1})
      $display("FAIL or_zero got result=%0d cb=%b zero=%b want 0 0 1", rsp_result, rsp_cb, rsp_zero);
    else n_pass++;
    tick();
    calc_junk = 1'b1;
    run_main(4'd0, 4'd0, 2'b11, 1'b0, 4'd6, lat);
    n_total++;
    if ({rsp_result, rsp_cb, rsp_zero} !== {5'd16, 1'b0, 1'b0})
      $display("FAIL or_cb_forced got result=%0d cb=%b zero=%b want 16 0 0", rsp_result, rsp_cb, rsp_zero);
    else n_pass++;
    tick();
    calc_junk = 1'b0;
    run_main(4'd5, 4'd5, 2'b01, 1'b0, 4'd7, lat);
    n_total++;
    if ({rsp_result, rsp_cb, rsp_zero} !== {5'd0, 1'b0, 1'b1})
      $display("FAIL sub_zero got result=%0d cb=%b zero=%b want 0 0 1", rsp_result, rsp_cb, rsp_zero);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    rsp_ready = 1'b0;
    run_main(4'd1, 4'd2, 2'b00, 1'b0, 4'd9, lat);
    cmd_valid = 1'b1; cmd_a = 4'd6; cmd_b = 4'd4; cmd_op = 2'b00; cmd_use_acc = 1'b0; cmd_tag = 4'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if ({rsp_valid, cmd_ready, rsp_result, rsp_tag, calc_a} !== {1'b1, 1'b0, 5'd3, 4'd9, 4'd1})
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b result=%0d tag=%0d calc_a=%0d want 1 0 3 9 1",
                 i, rsp_valid, cmd_ready, rsp_result, rsp_tag, calc_a);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    tick();
    n_total++;
    if ({rsp_valid, cmd_ready, calc_a} !== {1'b0, 1'b1, 4'd1})
      $display("FAIL bp_handshake got valid=%b ready=%b calc_a=%0d want 0 1 1", rsp_valid, cmd_ready, calc_a);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_total++;
    if ({calc_a, cmd_ready} !== {4'd6, 1'b0})
      $display("FAIL bp_second_accept got calc_a=%0d ready=%b want 6 0", calc_a, cmd_ready);
    else n_pass++;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 30) begin tick(); lat++; end
    n_total++;
    if ({rsp_result, rsp_tag} !== {5'd10, 4'd10})
      $display("FAIL bp_second_result got result=%0d tag=%0d want 10 10", rsp_result, rsp_tag);
    else n_pass++;
    $display("txn backpressure second result=%0d", rsp_result);
    tick();
    n_total++;
    if (op_count !== 8'd9) $display("FAIL bp_count got %0d want 9", op_count); else n_pass++;
  endtask

  task automatic test_reset_in_issue();
    int lat;
    bit seen = 0;
    cmd_valid = 1'b1; cmd_a = 4'd4; cmd_b = 4'd4; cmd_op = 2'b00; cmd_use_acc = 1'b0; cmd_tag = 4'd11;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0) seen = 1;
      tick();
    end
    n_total++;
    if (seen) $display("FAIL rst_issue_rsp got rsp_valid=1 want 0"); else n_pass++;
    n_total++;
    if ({op_count, busy, cmd_ready} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL rst_issue_state got count=%0d busy=%b ready=%b want 0 0 1", op_count, busy, cmd_ready);
    else n_pass++;
    run_main(4'd9, 4'd3, 2'b00, 1'b1, 4'd12, lat);
    n_total++;
    if ({calc_a, rsp_result} !== {4'd0, 5'd3})
      $display("FAIL rst_acc_cleared got calc_a=%0d result=%0d want 0 3", calc_a, rsp_result);
    else n_pass++;
    tick();
  endtask

  task automatic test_settle4_saturate();
    logic [1:0] want_cnt;
    int lat;
    for (int k = 0; k < 5; k++) begin
      cmd_valid2 = 1'b1; cmd_a2 = 4'(k + 1); cmd_b2 = 4'd2; cmd_op2 = 2'b00;
      tick();
      cmd_valid2 = 1'b0;
      lat = 0;
      while (rsp_valid2 !== 1'b1 && lat < 30) begin tick(); lat++; end
      $display("txn s4 a=%0d b=2 -> result=%0d lat=%0d", k + 1, rsp_result2, lat);
      n_total++;
      if ({lat[7:0], rsp_result2} !== {8'd5, 5'(k + 3)})
        $display("FAIL s4_latency_result op %0d got lat=%0d result=%0d want 5 %0d", k, lat, rsp_result2, k + 3);
      else n_pass++;
      tick();
      want_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      n_total++;
      if (op_count2 !== want_cnt)
        $display("FAIL s4_count op %0d got %0d want %0d", k, op_count2, want_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_logic();
    test_backpressure();
    test_reset_in_issue();
    test_settle4_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
